seg_shift_out: RTL

SEG_SHIFT_OUT -- requirements
Module: seg_shift_out

---
 rtl/seg_shift_out.sv | 104 ++++++++++
 1 files changed

// File: rtl/seg_shift_out.sv
// Serialises one 64-bit segment frame, LSB first, onto a 74HC164 shift-register chain.
// The shift clock is divided from clk by DIV, and the display is blanked while the chain shifts.
module seg_shift_out #(
  parameter int unsigned DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] SEG_TXT,
  output logic        seg_clk,
  output logic        seg_dat,
  output logic        seg_en,
  output logic        seg_clr_n,
  output logic        busy,
  output logic        done
);

  localparam int unsigned   PW      = $clog2(DIV) + 1;
  localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state_q;
  logic [63:0]   shadow_q;
  logic [63:0]   shadow_d;
  logic [6:0]    bit_cnt_q;
  logic [PW-1:0] phase_q;
  logic          seg_clk_q;
  logic          seg_dat_q;
  logic          seg_en_q;
  logic          seg_clr_n_q;
  logic          busy_q;
  logic          done_q;

  assign shadow_d = {1'b0, shadow_q[63:1]};

  // Each bit spends DIV cycles with seg_clk low, then DIV cycles high; data moves only at the end of the high phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      bit_cnt_q   <= '0;
      phase_q     <= '0;
      seg_clk_q   <= 1'b0;
      seg_dat_q   <= 1'b0;
      seg_en_q    <= 1'b0;
      seg_clr_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      seg_clr_n_q <= 1'b1;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          seg_clk_q <= 1'b0;
          if (start) begin
            shadow_q  <= SEG_TXT;
            bit_cnt_q <= '0;
            phase_q   <= '0;
            busy_q    <= 1'b1;
            seg_en_q  <= 1'b0;
            seg_dat_q <= SEG_TXT[0];
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (phase_q != PH_LAST) begin
            phase_q <= phase_q + PW'(1);
          end else begin
            phase_q <= '0;
            if (!seg_clk_q) begin
              seg_clk_q <= 1'b1;
            end else begin
              seg_clk_q <= 1'b0;
              shadow_q  <= shadow_d;
              seg_dat_q <= shadow_d[0];
              bit_cnt_q <= bit_cnt_q + 7'd1;
              if (bit_cnt_q == 7'd63) begin
                busy_q   <= 1'b0;
                seg_en_q <= 1'b1;
                done_q   <= 1'b1;
                state_q  <= DONE;
              end
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign seg_clk   = seg_clk_q;
  assign seg_dat   = seg_dat_q;
  assign seg_en    = seg_en_q;
  assign seg_clr_n = seg_clr_n_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
